regfile_param: RTL and testbench

//  Parametrised multi-ported register file: DEPTH words of WIDTH bits, one write port, two read ports.

---
 rtl/regfile_param.sv | 98 +++++++++
 tb/tb_regfile_param.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised register file, one write port, two read ports
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int RD_REG   = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_en;
  logic [WIDTH-1:0] rd_a_val;
  logic [WIDTH-1:0] rd_b_val;

  // Writes to the hardwired zero entry are dropped before they reach the array.
  assign wr_en = we && !((ZERO_REG != 0) && (waddr == '0));

  // Next array contents: only the addressed entry changes on a qualified write.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage array, cleared asynchronously so a write coinciding with reset is lost.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read value per port: stored word, optionally overridden by same-cycle write data,
  // and forced to zero for entry 0 last so forwarding can never leak into it.
  always_comb begin
    rd_a_val = mem_q[raddr_a];
    rd_b_val = mem_q[raddr_b];
    if ((BYPASS != 0) && we && (waddr == raddr_a)) begin
      rd_a_val = wdata;
    end
    if ((BYPASS != 0) && we && (waddr == raddr_b)) begin
      rd_b_val = wdata;
    end
    if ((ZERO_REG != 0) && (raddr_a == '0)) begin
      rd_a_val = '0;
    end
    if ((ZERO_REG != 0) && (raddr_b == '0)) begin
      rd_b_val = '0;
    end
  end

  if (RD_REG != 0) begin : g_rd_reg
    logic [WIDTH-1:0] rdata_a_q;
    logic [WIDTH-1:0] rdata_b_q;
    logic [WIDTH-1:0] rdata_a_d;
    logic [WIDTH-1:0] rdata_b_d;

    // The registered read captures exactly what a combinational read would show this cycle.
    always_comb begin
      rdata_a_d = rd_a_val;
      rdata_b_d = rd_b_val;
    end

    // Read registers hold zero through reset and until the first edge after release.
    always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
        rdata_a_q <= '0;
        rdata_b_q <= '0;
      end else begin
        rdata_a_q <= rdata_a_d;
        rdata_b_q <= rdata_b_d;
      end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;
  end else begin : g_rd_comb
    assign rdata_a = rd_a_val;
    assign rdata_b = rd_b_val;
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - randomized self-checking bench for regfile_param
module tb_regfile_param;

  logic        clk;
  logic        clr;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic [31:0] ra0, rb0, ra1, rb1;
  logic [7:0]  ra2, rb2;

  int n_checks = 0;
  int n_pass   = 0;

  // reference storage for each configuration
  logic [31:0] m0 [32];
  logic [31:0] m1 [32];
  logic [7:0]  m2 [8];
  logic [31:0] exp1_a, exp1_b;

  // default: zero entry, bypass, combinational read
  regfile_param #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_REG(1), .BYPASS(1), .RD_REG(0)) u_dut0 (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra0), .rdata_b(rb0));

  // zero entry, no bypass, registered read
  regfile_param #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_REG(1), .BYPASS(0), .RD_REG(1)) u_dut1 (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra1), .rdata_b(rb1));

  // small array, ordinary entry 0, no bypass, combinational read
  regfile_param #(.WIDTH(8), .DEPTH(8), .AW(3), .ZERO_REG(0), .BYPASS(0), .RD_REG(0)) u_dut2 (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr[2:0]), .wdata(wdata[7:0]),
    .raddr_a(raddr_a[2:0]), .raddr_b(raddr_b[2:0]), .rdata_a(ra2), .rdata_b(rb2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] f0(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (we && waddr == a) return wdata;
    return m0[a];
  endfunction

  function automatic logic [31:0] f1(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    return m1[a];
  endfunction

  function automatic logic [31:0] f2(input logic [4:0] a);
    return {24'h0, m2[a[2:0]]};
  endfunction

  task automatic clear_models();
    for (int i = 0; i < 32; i++) begin
      m0[i] = '0;
      m1[i] = '0;
    end
    for (int i = 0; i < 8; i++) m2[i] = '0;
    exp1_a = '0;
    exp1_b = '0;
  endtask

  // Compare all ports mid-cycle, then advance the models across the rising edge.
  task automatic tick();
    logic [31:0] nxt_a, nxt_b;
    @(negedge clk);
    check("a0", ra0, f0(raddr_a));
    check("b0", rb0, f0(raddr_b));
    check("a1", ra1, exp1_a);
    check("b1", rb1, exp1_b);
    check("a2", {24'h0, ra2}, f2(raddr_a));
    check("b2", {24'h0, rb2}, f2(raddr_b));
    nxt_a = f1(raddr_a);
    nxt_b = f1(raddr_b);
    @(posedge clk);
    if (clr) begin
      if (we) begin
        if (waddr != 5'd0) begin
          m0[waddr] = wdata;
          m1[waddr] = wdata;
        end
        m2[waddr[2:0]] = wdata[7:0];
      end
      exp1_a = nxt_a;
      exp1_b = nxt_b;
    end else begin
      exp1_a = '0;
      exp1_b = '0;
    end
    #1;
  endtask

  initial begin
    clr = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    clear_models();
    @(posedge clk); @(posedge clk); #1;
    check("rst_a0", ra0, 32'h0);
    check("rst_a1", ra1, 32'h0);
    check("rst_b1", rb1, 32'h0);
    clr = 1'b1;
    tick();

    // write then read back
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr_a = 5'd5; raddr_b = 5'd0;
    tick();
    we = 1'b0;
    #1;
    check("wr_a0", ra0, 32'hDEADBEEF);
    check("wr_a1_pre", ra1, 32'h0);
    tick();
    check("wr_a1", ra1, 32'hDEADBEEF);

    // zero entry ignores writes, including the bypass path
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr_a = 5'd0; raddr_b = 5'd0;
    #1;
    check("z_a0_wr", ra0, 32'h0);
    check("z_b0_wr", rb0, 32'h0);
    tick();
    we = 1'b0;
    tick();
    check("z_a0", ra0, 32'h0);
    check("z_b1", rb1, 32'h0);
    check("z_small", {24'h0, ra2}, 32'hFF);

    // bypass versus old value
    we = 1'b1; waddr = 5'd7; wdata = 32'h1; raddr_a = 5'd1; raddr_b = 5'd7;
    tick();
    wdata = 32'h2;
    #1;
    check("byp_b0", rb0, 32'h2);
    check("nobyp_b2", {24'h0, rb2}, 32'h1);
    tick();
    we = 1'b0;
    #1;
    check("byp_b2_after", {24'h0, rb2}, 32'h2);
    check("nobyp_b1", rb1, 32'h1);
    tick();
    check("nobyp_b1_after", rb1, 32'h2);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      we = ($urandom_range(0, 2) != 0);
      waddr = 5'($urandom_range(0, 31));
      wdata = $urandom;
      raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr_b = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      tick();
    end

    // asynchronous reset pulse between edges clears everything at once
    we = 1'b0;
    #2;
    clr = 1'b0;
    clear_models();
    #1;
    for (int i = 0; i < 32; i++) begin
      raddr_a = 5'(i);
      raddr_b = 5'(31 - i);
      #1;
      check("clr_a0", ra0, 32'h0);
      check("clr_b0", rb0, 32'h0);
      check("clr_a1", ra1, 32'h0);
      check("clr_b2", {24'h0, rb2}, 32'h0);
    end
    @(posedge clk); #1;
    clr = 1'b1;

    // reset held across a write edge: the write is lost
    we = 1'b1; waddr = 5'd3; wdata = 32'h11; raddr_a = 5'd3; raddr_b = 5'd3;
    tick();
    wdata = 32'hA5A5A5A5;
    clr = 1'b0;
    clear_models();
    @(posedge clk); #1;
    clr = 1'b1;
    we = 1'b0;
    #1;
    check("mid_a0", ra0, 32'h0);
    check("mid_a1", ra1, 32'h0);
    check("mid_a2", {24'h0, ra2}, 32'h0);
    tick();
    check("mid_a1_edge", ra1, 32'h0);

    // small array: entry i holds i+1, every address pair on both ports
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'(i + 1);
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        raddr_a = 5'(i);
        raddr_b = 5'(j);
        #1;
        check("p_a2", {24'h0, ra2}, 32'(i + 1));
        check("p_b2", {24'h0, rb2}, 32'(j + 1));
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
